lutnn_top: RTL and testbench
============================

# lutnn_top

Clocked lookup-table neural network (LUTNN) classifier for binarized, bit-reversed 20x20 MNIST images. It takes a 400-bit pixel vector and produces a 10-bit one-hot digit class. The block has two layers of programmable 2-input LUTs, per-class popcount and argmax. It is the top of the inference datapath, and its LUT truth tables are written through a simple configuration port.

## Interface
- NET_INPUTS, default 400: input pixel bits. The design is specified for 400 only.
- NET_OUTPUT, default 10: number of classes, one-hot output width.
- CLK  in  1  sole clock. All state changes on the rising edge.
- RST  in  1  synchronous, active-high reset.
- NET_I  in  400  binarized image. Bit i is pixel i.
- CFG_WE  in  1  truth-table write enable.
- CFG_ADDR  in  9  LUT index. 0..199 select layer-1 nodes; 200..299 select layer-2 nodes.
- CFG_DATA  in  4  truth table to write.
- NET_O  out  10  registered one-hot class. Bit c means digit c.

## Operation
- Input register: IN_R <= NET_I every cycle.
- Layer 1 (200 LUT2 nodes):
  - Node n reads a = IN_R[2n], b = IN_R[2n+1].
  - Output is T1[n][{b,a}], so table bit 0 is selected when a=b=0, and bit 3 when both are 1.
- Layer 2 (100 LUT2 nodes):
  - Node m reads a = L1[2m], b = L1[2m+1].
  - Output is T2[m][{b,a}].
- Class c (0..9) owns L2 nodes 10c..10c+9. These trace back to NET_I bits 40c..40c+39.
- Score[c] = popcount of its 10 L2 outputs. Range 0..10, 4 bits unsigned, no overflow possible.
- Argmax selects the class with the highest score. Ties resolve to the lowest class index.
- NET_O <= one-hot of the argmax. Exactly one bit is set at all times after the first post-reset result.
- Configuration write: when CFG_WE=1 and RST=0:
  - CFG_ADDR < 200 writes T1[CFG_ADDR] <= CFG_DATA.
  - 200 ≤ CFG_ADDR < 300 writes T2[CFG_ADDR-200] <= CFG_DATA.
  - CFG_ADDR ≥ 300 is ignored and nothing changes.
- Reset (RST=1 at an edge):
  - IN_R <= 0.
  - NET_O <= 10'h000.
  - All 300 tables <= 4'b1000 (AND).
  - CFG_WE is ignored.
- Default network (all tables AND): an L2 node is 1 only when all 4 of its input pixels are 1.

## Timing
- NET_I sampled at edge t is reflected in NET_O after edge t+1. Latency is 2 edges, throughput 1 image per cycle.
- A table written at edge t is used by the argmax computed at edge t+1. So NET_O reflects the new table after edge t+1, for the input held in IN_R.
- NET_O is 0 during reset and on the first edge after release (IN_R is still 0 then).
  - From the second edge after release, NET_O is one-hot.
  - With default tables and NET_I=0 this gives 10'h001.
- Reset asserted mid-operation takes effect at the next edge. It discards in-flight data and any configuration; nothing is retained.
- A simultaneous CFG_WE and RST: reset wins.
- No handshake. Inputs must be stable around each rising edge.

## Test plan
- Reset: RST=1 for 2 cycles then 0, NET_I=0 -> NET_O=10'h000 while in reset and one edge after; then 10'h001.
- Default tables, NET_I all ones -> every score is 10, tie -> NET_O=10'h001. NET_I = only bits 160..199 set -> NET_O=10'h010, 2 edges after apply.
- Write CFG_DATA=4'b1111 to addresses 270..279, NET_I=0 -> NET_O=10'h080. A write to address 300 or 511 leaves NET_O unchanged.
- Tie: default tables, NET_I bits 80..119 and 280..319 set -> NET_O=10'h004. Clearing bits 80..83 -> 10'h080.
- Mid-run reset after the address 270..279 writes -> NET_O=0 at the next edge. With NET_I=0, NET_O returns to 10'h001, proving the tables reset to AND.
- Stream the five MNIST digits (7, 2, 1, 0, 4), one per cycle, against a bit-accurate software model of the programmed tables. NET_O must match the model with 2-edge latency every cycle, with no bubbles.

Source files
------------

// File: rtl/lutnn_if.sv
// Image/config bus of the LUT network classifier: pixel vector and truth-table
// write port in, registered one-hot class out.
interface lutnn_if #(
    parameter int NET_INPUTS = 400,
    parameter int NET_OUTPUT = 10
);
    logic [NET_INPUTS-1:0] NET_I;
    logic                  CFG_WE;
    logic [8:0]            CFG_ADDR;
    logic [3:0]            CFG_DATA;
    logic [NET_OUTPUT-1:0] NET_O;

    modport master (output NET_I, CFG_WE, CFG_ADDR, CFG_DATA, input NET_O);
    modport slave  (input NET_I, CFG_WE, CFG_ADDR, CFG_DATA, output NET_O);
endinterface

// File: rtl/lutnn_top.sv
// Two-layer LUT2 network with per-class popcount and lowest-index argmax.
// Input register, then one registered stage for the one-hot class.
module lutnn_top #(
    parameter int NET_INPUTS = 400,
    parameter int NET_OUTPUT = 10
) (
    input  logic   CLK,
    input  logic   RST,
    lutnn_if.slave bus
);
    localparam int N1  = NET_INPUTS / 2;
    localparam int N2  = N1 / 2;
    localparam int NPC = N2 / NET_OUTPUT;
    localparam int A1W = $clog2(N1);
    localparam int A2W = $clog2(N2);
    localparam int SW  = $clog2(NPC + 1);
    localparam int IW  = $clog2(NET_OUTPUT);
    localparam logic [3:0] TBL_AND = 4'b1000;

    logic [NET_INPUTS-1:0] in_q;
    logic                  vld_q;
    logic [NET_OUTPUT-1:0] net_o_q, net_o_d;
    logic [3:0]            t1_q [N1];
    logic [3:0]            t2_q [N2];
    logic [N1-1:0]         l1;
    logic [N2-1:0]         l2;
    logic [SW-1:0]         score [NET_OUTPUT];

    // Write decode: addresses at or above N1+N2 hit neither table.
    logic           we1, we2;
    logic [8:0]     off2;
    logic [A1W-1:0] a1;
    logic [A2W-1:0] a2;

    assign we1  = bus.CFG_WE && (bus.CFG_ADDR < 9'(N1));
    assign we2  = bus.CFG_WE && (bus.CFG_ADDR >= 9'(N1)) && (bus.CFG_ADDR < 9'(N1 + N2));
    assign off2 = bus.CFG_ADDR - 9'(N1);
    assign a1   = bus.CFG_ADDR[A1W-1:0];
    assign a2   = off2[A2W-1:0];

    genvar n;
    generate
        for (n = 0; n < N1; n++) begin : g_l1
            always_ff @(posedge CLK) begin
                if (RST)
                    t1_q[n] <= TBL_AND;
                else if (we1 && a1 == A1W'(n))
                    t1_q[n] <= bus.CFG_DATA;
            end
            assign l1[n] = t1_q[n][{in_q[2*n+1], in_q[2*n]}];
        end
        for (n = 0; n < N2; n++) begin : g_l2
            always_ff @(posedge CLK) begin
                if (RST)
                    t2_q[n] <= TBL_AND;
                else if (we2 && a2 == A2W'(n))
                    t2_q[n] <= bus.CFG_DATA;
            end
            assign l2[n] = t2_q[n][{l1[2*n+1], l1[2*n]}];
        end
    endgenerate

    always_comb begin
        for (int c = 0; c < NET_OUTPUT; c++) begin
            score[c] = '0;
            for (int j = 0; j < NPC; j++)
                score[c] = score[c] + SW'(l2[c*NPC+j]);
        end
    end

    // Strict greater-than keeps the lowest class index on ties.
    logic [SW-1:0] best_s;
    logic [IW-1:0] best_i;
    always_comb begin
        best_s  = score[0];
        best_i  = '0;
        for (int c = 1; c < NET_OUTPUT; c++) begin
            if (score[c] > best_s) begin
                best_s = score[c];
                best_i = IW'(c);
            end
        end
        net_o_d         = '0;
        net_o_d[best_i] = 1'b1;
    end

    // vld_q holds the output at zero until IN_R carries a post-reset sample.
    always_ff @(posedge CLK) begin
        if (RST) begin
            in_q    <= '0;
            vld_q   <= 1'b0;
            net_o_q <= '0;
        end else begin
            in_q    <= bus.NET_I;
            vld_q   <= 1'b1;
            net_o_q <= vld_q ? net_o_d : '0;
        end
    end

    assign bus.NET_O = net_o_q;
endmodule

// File: tb/tb_lutnn_top.sv
// Directed bench for lutnn_top: reset, default AND network, table writes,
// tie-break, mid-run reset and a streamed digit sequence against a model.
module tb_lutnn_top;
    logic CLK = 1'b0;
    logic RST = 1'b1;
    int   n_run  = 0;
    int   n_fail = 0;

    lutnn_if #(.NET_INPUTS(400), .NET_OUTPUT(10)) bus ();
    lutnn_top #(.NET_INPUTS(400), .NET_OUTPUT(10)) dut (.CLK(CLK), .RST(RST), .bus(bus.slave));

    always #5 CLK = ~CLK;

    logic [3:0] m1 [200];
    logic [3:0] m2 [100];

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic cfg_write(input int addr, input logic [3:0] data);
        bus.CFG_WE   = 1'b1;
        bus.CFG_ADDR = 9'(addr);
        bus.CFG_DATA = data;
        step();
        bus.CFG_WE   = 1'b0;
    endtask

    function automatic logic [9:0] model(input logic [399:0] img);
        logic [199:0] a;
        logic [99:0]  b;
        int sc, best, bi;
        for (int k = 0; k < 200; k++) a[k] = m1[k][{img[2*k+1], img[2*k]}];
        for (int k = 0; k < 100; k++) b[k] = m2[k][{a[2*k+1], a[2*k]}];
        best = -1;
        bi   = 0;
        for (int c = 0; c < 10; c++) begin
            sc = 0;
            for (int j = 0; j < 10; j++) sc += int'(b[10*c+j]);
            if (sc > best) begin best = sc; bi = c; end
        end
        return 10'b1 << bi;
    endfunction

    // Rough 20x20 digit sketches; pixel (r,c) lands on bit 399-(20r+c).
    function automatic logic [399:0] digit_img(input int d);
        logic [399:0] v;
        v = '0;
        for (int r = 0; r < 20; r++)
            for (int c = 0; c < 20; c++) begin
                bit on;
                on = 0;
                case (d)
                    7: on = (r inside {[2:3]} && c inside {[3:16]}) ||
                            (r inside {[4:17]} && (c == 16 - (r-4)*10/13 || c == 15 - (r-4)*10/13));
                    2: on = (r inside {[3:4]} && c inside {[5:14]}) ||
                            (r inside {[5:9]} && c inside {[13:14]}) ||
                            (r inside {[10:14]} && c == 14 - (r-9)*9/6) ||
                            (r inside {[15:16]} && c inside {[4:15]});
                    1: on = (r inside {[2:17]} && c inside {[9:10]});
                    0: on = (r inside {[3:16]} && c inside {[5:14]}) &&
                            !(r inside {[5:14]} && c inside {[7:12]});
                    4: on = (r inside {[2:17]} && c inside {[13:14]}) ||
                            (r inside {[2:10]} && c inside {[5:6]}) ||
                            (r inside {[10:11]} && c inside {[5:16]});
                    default: on = 0;
                endcase
                if (on) v[399 - (20*r + c)] = 1'b1;
            end
        return v;
    endfunction

    task automatic test_reset();
        RST = 1'b1;
        bus.NET_I = '0;
        step();
        n_run++; if (bus.NET_O !== 10'h000) begin n_fail++; $display("FAIL reset_cyc1 got %h want %h", bus.NET_O, 10'h000); end
        step();
        n_run++; if (bus.NET_O !== 10'h000) begin n_fail++; $display("FAIL reset_cyc2 got %h want %h", bus.NET_O, 10'h000); end
        RST = 1'b0;
        step();
        n_run++; if (bus.NET_O !== 10'h000) begin n_fail++; $display("FAIL reset_release1 got %h want %h", bus.NET_O, 10'h000); end
        step();
        n_run++; if (bus.NET_O !== 10'h001) begin n_fail++; $display("FAIL reset_release2 got %h want %h", bus.NET_O, 10'h001); end
    endtask

    task automatic test_default();
        logic [399:0] v;
        bus.NET_I = '1;
        step(); step();
        n_run++; if (bus.NET_O !== 10'h001) begin n_fail++; $display("FAIL default_all_ones got %h want %h", bus.NET_O, 10'h001); end
        v = '0;
        v[199:160] = '1;
        bus.NET_I = v;
        step();
        n_run++; if (bus.NET_O !== 10'h001) begin n_fail++; $display("FAIL default_latency got %h want %h", bus.NET_O, 10'h001); end
        step();
        n_run++; if (bus.NET_O !== 10'h010) begin n_fail++; $display("FAIL default_class4 got %h want %h", bus.NET_O, 10'h010); end
    endtask

    task automatic test_cfg();
        bus.NET_I = '0;
        step(); step();
        for (int a = 270; a < 280; a++) cfg_write(a, 4'b1111);
        step();
        n_run++; if (bus.NET_O !== 10'h080) begin n_fail++; $display("FAIL cfg_class7 got %h want %h", bus.NET_O, 10'h080); end
        cfg_write(300, 4'b0000);
        cfg_write(370, 4'b0000);
        cfg_write(511, 4'b0000);
        step(); step();
        n_run++; if (bus.NET_O !== 10'h080) begin n_fail++; $display("FAIL cfg_out_of_range got %h want %h", bus.NET_O, 10'h080); end
    endtask

    task automatic test_mid_reset();
        RST          = 1'b1;
        bus.CFG_WE   = 1'b1;
        bus.CFG_ADDR = 9'd271;
        bus.CFG_DATA = 4'b1111;
        step();
        n_run++; if (bus.NET_O !== 10'h000) begin n_fail++; $display("FAIL midreset_clear got %h want %h", bus.NET_O, 10'h000); end
        RST        = 1'b0;
        bus.CFG_WE = 1'b0;
        step();
        n_run++; if (bus.NET_O !== 10'h000) begin n_fail++; $display("FAIL midreset_release got %h want %h", bus.NET_O, 10'h000); end
        step();
        n_run++; if (bus.NET_O !== 10'h001) begin n_fail++; $display("FAIL midreset_tables got %h want %h", bus.NET_O, 10'h001); end
    endtask

    task automatic test_tie();
        logic [399:0] v;
        v = '0;
        v[119:80]  = '1;
        v[319:280] = '1;
        bus.NET_I = v;
        step(); step();
        n_run++; if (bus.NET_O !== 10'h004) begin n_fail++; $display("FAIL tie_lowest got %h want %h", bus.NET_O, 10'h004); end
        v[83:80] = '0;
        bus.NET_I = v;
        step(); step();
        n_run++; if (bus.NET_O !== 10'h080) begin n_fail++; $display("FAIL tie_broken got %h want %h", bus.NET_O, 10'h080); end
    endtask

    task automatic test_stream();
        logic [399:0] imgs [5];
        logic [9:0]   expv [5];
        int digits [5] = '{7, 2, 1, 0, 4};
        bus.NET_I = '0;
        for (int k = 0; k < 200; k++) begin
            m1[k] = 4'((k*5 + 3) % 16);
            cfg_write(k, m1[k]);
        end
        for (int k = 0; k < 100; k++) begin
            m2[k] = 4'((k*11 + 6) % 16);
            cfg_write(200 + k, m2[k]);
        end
        for (int k = 0; k < 5; k++) begin
            imgs[k] = digit_img(digits[k]);
            expv[k] = model(imgs[k]);
        end
        for (int k = 0; k < 6; k++) begin
            if (k < 5) bus.NET_I = imgs[k];
            step();
            if (k >= 1) begin
                n_run++;
                if (bus.NET_O !== expv[k-1]) begin
                    n_fail++;
                    $display("FAIL stream_digit%0d got %h want %h", digits[k-1], bus.NET_O, expv[k-1]);
                end
            end
        end
    endtask

    initial begin
        bus.NET_I    = '0;
        bus.CFG_WE   = 1'b0;
        bus.CFG_ADDR = '0;
        bus.CFG_DATA = '0;
        test_reset();
        test_default();
        test_cfg();
        test_mid_reset();
        test_tie();
        test_stream();
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
